// File: rtl/ps2_frame_rx.sv
// PS/2 keyboard frame receiver.
// Synchronises the raw PS/2 pins, de-glitches the clock line, shifts in
// 11-bit frames (start, 8 data LSB-first, odd parity, stop), keeps a 4-byte
// history word and guards every frame with an inter-edge watchdog.
module ps2_frame_rx #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        kclk,
  input  logic        kdata,
  output logic [31:0] keycode,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  output logic        frame_err,
  output logic        busy
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_MAX   = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]      FLT_LAST = 4'(FILTER_LEN - 1);

  typedef enum logic {
    IDLE,
    RECV
  } state_t;

  state_t          state;
  logic            kclk_s1, kclk_s2;
  logic            kdata_s1, kdata_s2;
  logic            kclk_f, kclk_f_q;
  logic [3:0]      flt_cnt;
  logic [3:0]      bit_cnt;
  logic [7:0]      shreg;
  logic            par;
  logic [WD_W-1:0] wd_cnt;
  logic            fall;

  // Two-flop synchronisers on both pins, parked at the bus idle level.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the two sync stages into one.
  always_ff @(posedge clk) begin
    if (rst) begin
      kclk_s1  <= 1'b1;
      kclk_s2  <= 1'b1;
      kdata_s1 <= 1'b1;
      kdata_s2 <= 1'b1;
    end else begin
      kclk_s1  <= kclk;
      kclk_s2  <= kclk_s1;
      kdata_s1 <= kdata;
      kdata_s2 <= kdata_s1;
    end
  end

  // Glitch filter: the filtered clock only follows the synced clock after
  // FILTER_LEN consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      kclk_f   <= 1'b1;
      kclk_f_q <= 1'b1;
      flt_cnt  <= '0;
    end else begin
      kclk_f_q <= kclk_f;
      if (kclk_s2 == kclk_f) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FLT_LAST) begin
        kclk_f  <= kclk_s2;
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + 4'd1;
      end
    end
  end

  // One-cycle strobe in the cycle the filtered clock has just dropped.
  assign fall = kclk_f_q & ~kclk_f;

  // Frame FSM: start detection, bit shifting, frame check, watchdog and the
  // registered strobes/history outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par        <= 1'b0;
      wd_cnt     <= '0;
      keycode    <= '0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          wd_cnt <= '0;
          // A high start bit is simply ignored; the next falling edge retries.
          if (fall && !kdata_s2) begin
            state   <= RECV;
            busy    <= 1'b1;
            bit_cnt <= '0;
            shreg   <= '0;
          end
        end
        RECV: begin
          // A falling edge wins over a watchdog expiry in the same cycle.
          if (fall) begin
            wd_cnt  <= '0;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt < 4'd8) begin
              shreg <= {kdata_s2, shreg[7:1]};
            end else if (bit_cnt == 4'd8) begin
              par <= kdata_s2;
            end else begin
              state   <= IDLE;
              busy    <= 1'b0;
              bit_cnt <= '0;
              // Odd parity over data+parity, and the stop bit must be high.
              if ((^{shreg, par}) && kdata_s2) begin
                byte_out   <= shreg;
                keycode    <= {keycode[23:0], shreg};
                byte_valid <= 1'b1;
              end else begin
                frame_err <= 1'b1;
              end
            end
          end else if (wd_cnt == WD_MAX) begin
            state     <= IDLE;
            busy      <= 1'b0;
            bit_cnt   <= '0;
            wd_cnt    <= '0;
            frame_err <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Self-checking bench for ps2_frame_rx: a stimulus process drives PS/2 frames
// and pushes expected strobes into a queue; a monitor pops and compares.
module tb_ps2_frame_rx;

  localparam int F  = 4;
  localparam int TO = 200;
  localparam int HALF_MIN = 2 * (F + 2);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        kclk = 1'b1;
  logic        kdata = 1'b1;
  logic [31:0] keycode;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        frame_err;
  logic        busy;

  ps2_frame_rx #(
    .FILTER_LEN    (F),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .kclk      (kclk),
    .kdata     (kdata),
    .keycode   (keycode),
    .byte_out  (byte_out),
    .byte_valid(byte_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          err;
    logic [31:0] kc;
    logic [7:0]  bo;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          tests = 0;
  int          fails = 0;
  bit          in_reset = 1'b1;
  logic [31:0] prev_kc = '0;
  logic [31:0] mdl_kc = '0;
  logic [7:0]  mdl_bo = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: every strobe must match the oldest expected event; keycode must
  // hold steady between strobes.
  always @(negedge clk) begin
    if (!in_reset) begin
      if (byte_valid && frame_err) begin
        fails++;
        $display("FAIL strobe_overlap: byte_valid and frame_err both high at %0t", $time);
      end
      if (byte_valid || frame_err) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_strobe: byte_valid=%0b frame_err=%0b with none expected at %0t",
                   byte_valid, frame_err, $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("strobe_kind_err", {31'd0, frame_err}, {31'd0, mon_e.err});
          check("keycode", keycode, mon_e.kc);
          check("byte_out", {24'd0, byte_out}, {24'd0, mon_e.bo});
          check("busy_at_strobe", {31'd0, busy}, 32'd0);
        end
      end else if (keycode !== prev_kc) begin
        fails++;
        $display("FAIL keycode_hold: got 0x%08h expected 0x%08h at %0t", keycode, prev_kc, $time);
      end
    end
    prev_kc = keycode;
  end

  // Reference model: pure frame-level rules, no knowledge of the RTL timing.
  task automatic model_frame(input logic [7:0] d, input logic p, input logic s);
    exp_t e;
    if ((($countones(d) + int'(p)) % 2 == 1) && s) begin
      mdl_bo = d;
      mdl_kc = {mdl_kc[23:0], d};
      e.err  = 1'b0;
    end else begin
      e.err = 1'b1;
    end
    e.kc = mdl_kc;
    e.bo = mdl_bo;
    exp_q.push_back(e);
  endtask

  task automatic model_error();
    exp_t e;
    e.err = 1'b1;
    e.kc  = mdl_kc;
    e.bo  = mdl_bo;
    exp_q.push_back(e);
  endtask

  task automatic ps2_bit(input logic b, input int half);
    kdata = b;
    repeat (half) @(negedge clk);
    kclk = 1'b0;
    repeat (half) @(negedge clk);
    kclk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                            input int half);
    logic p, s;
    p = (~^d) ^ bad_par;
    s = ~bad_stop;
    model_frame(d, p, s);
    ps2_bit(1'b0, half);
    check("busy_in_frame", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 8; i++) ps2_bit(d[i], half);
    ps2_bit(p, half);
    ps2_bit(s, half);
    kdata = 1'b1;
    repeat (half) @(negedge clk);
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic pulse_reset();
    in_reset = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mdl_kc = '0;
    mdl_bo = '0;
    exp_q.delete();
    check("rst_keycode", keycode, 32'd0);
    check("rst_byte_out", {24'd0, byte_out}, 32'd0);
    check("rst_byte_valid", {31'd0, byte_valid}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    in_reset = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("FAIL sim_timeout: simulation did not finish, tests=%0d", tests);
    $fatal(1, "time limit");
  end

  initial begin
    bit busy_seen;
    repeat (4) @(negedge clk);
    pulse_reset();
    repeat (5) @(negedge clk);

    // Single good frame 0x1C.
    send_frame(8'h1C, 1'b0, 1'b0, 25);
    wait_drain(100, "drain_good");
    check("good_keycode", keycode, 32'h0000001C);

    // Byte history.
    send_frame(8'hF0, 1'b0, 1'b0, 25);
    send_frame(8'h1C, 1'b0, 1'b0, 25);
    wait_drain(100, "drain_history");
    check("history_keycode", keycode, 32'h001CF01C);

    // Bad parity, then bad stop.
    send_frame(8'h1C, 1'b1, 1'b0, 25);
    send_frame(8'h1C, 1'b0, 1'b1, 25);
    wait_drain(100, "drain_bad");
    check("bad_keycode_kept", keycode, 32'h001CF01C);

    // Timeout: start plus four data bits, then silence.
    model_error();
    ps2_bit(1'b0, 20);
    for (int i = 0; i < 4; i++) ps2_bit(1'(i & 1), 20);
    repeat (TO + 10) @(negedge clk);
    wait_drain(100, "drain_timeout");
    check("timeout_busy", {31'd0, busy}, 32'd0);
    send_frame(8'h5A, 1'b0, 1'b0, 20);
    wait_drain(100, "drain_recover");
    check("recover_low_byte", {24'd0, keycode[7:0]}, 32'h5A);

    // Glitch rejection while idle.
    busy_seen = 1'b0;
    repeat (20) begin
      kclk = 1'b0;
      repeat (F - 1) begin
        @(negedge clk);
        busy_seen |= busy;
      end
      kclk = 1'b1;
      repeat (10) begin
        @(negedge clk);
        busy_seen |= busy;
      end
    end
    check("glitch_busy", {31'd0, busy_seen}, 32'd0);
    model_error();
    kdata = 1'b0;
    kclk  = 1'b0;
    repeat (F + 4) @(negedge clk);
    kclk = 1'b1;
    repeat (2) @(negedge clk);
    check("long_pulse_busy", {31'd0, busy}, 32'd1);
    kdata = 1'b1;
    wait_drain(TO + 100, "drain_long_pulse");

    // Reset after the sixth edge of a frame.
    ps2_bit(1'b0, 20);
    for (int i = 0; i < 5; i++) ps2_bit(1'b1, 20);
    pulse_reset();
    send_frame(8'h29, 1'b0, 1'b0, 20);
    wait_drain(100, "drain_after_reset");
    check("reset_then_frame", keycode, 32'h00000029);

    // Randomised frames with occasional parity/stop corruption.
    for (int k = 0; k < 24; k++) begin
      logic [7:0] d;
      int r;
      d = 8'($urandom);
      r = $urandom_range(0, 9);
      send_frame(d, r == 0, r == 1, $urandom_range(HALF_MIN, 30));
    end
    wait_drain(100, "drain_random");

    repeat (10) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
